// File: rtl/axil_sram_responder.sv
// ---------------------------------------------------------------------------
// axil_sram_responder
//
// AXI4-Lite subordinate backed by a word-addressed register-array memory.
// It sits at the responder end of the link that the Renode bus controller
// drives, so co-simulation sees real RTL response timing. The write channel
// (AW/W/B) and the read channel (AR/R) each have their own FSM and never
// stall one another.
//
// Parameters:
//   ADDR_WIDTH  - width of awaddr/araddr
//   DATA_WIDTH  - data bus width (32 or 64)
//   DEPTH_WORDS - number of DATA_WIDTH words in memory (power of two)
//   BASE_ADDR   - byte address of word 0
//
// Ports:
//   aclk, areset_n                 - clock, asynchronous active-low reset
//   awvalid/awready/awaddr/awprot  - write address channel (awprot ignored)
//   wvalid/wready/wdata/wstrb      - write data channel with byte enables
//   bvalid/bready/bresp            - write response channel
//   arvalid/arready/araddr/arprot  - read address channel (arprot ignored)
//   rvalid/rready/rdata/rresp      - read data channel
//
// Optional feature macro: AXIL_SRAM_RANGE_CHECK_EN
//   defined   - out-of-range accesses answer SLVERR; writes are dropped and
//               reads return zero
//   undefined - the word index wraps modulo DEPTH_WORDS (addresses alias)
//               and every response is OKAY
// ---------------------------------------------------------------------------
module axil_sram_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp
);

  localparam int STRB_W      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT  = $clog2(STRB_W);
  localparam int IDX_W       = $clog2(DEPTH_WORDS);
  localparam int RANGE_BYTES = DEPTH_WORDS * STRB_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t r_wstate, w_wstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;

  logic                  r_out_en;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [1:0]            r_bresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
  logic                  w_wr_ok, w_rd_ok;
  logic                  w_unused_prot;

  assign w_unused_prot = ^{awprot, arprot};

  // Readies stay low while in reset and rise on the first edge after release.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_out_en <= 1'b0;
    else           r_out_en <= 1'b1;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  // Next-state and ready/valid decode. Only raw valids and state are read
  // here so the handshake wires below do not loop back into this block.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_rstate_nxt = r_rstate;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    arready      = 1'b0;
    rvalid       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        awready = r_out_en;
        wready  = r_out_en;
        if (r_out_en) begin
          if (awvalid && wvalid) w_wstate_nxt = W_RESP;
          else if (awvalid)      w_wstate_nxt = W_HAVE_ADDR;
          else if (wvalid)       w_wstate_nxt = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        wready = 1'b1;
        if (wvalid) w_wstate_nxt = W_RESP;
      end
      W_HAVE_DATA: begin
        awready = 1'b1;
        if (awvalid) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
    case (r_rstate)
      R_IDLE: begin
        arready = r_out_en;
        if (r_out_en && arvalid) w_rstate_nxt = R_RESP;
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_ar_hs = arvalid && arready;

  // The write commits on the edge where the second of the AW/W beats lands;
  // whichever beat arrived earlier is taken from its holding register.
  assign w_commit  = (r_wstate == W_IDLE && w_aw_hs && w_w_hs) ||
                     (r_wstate == W_HAVE_ADDR && w_w_hs) ||
                     (r_wstate == W_HAVE_DATA && w_aw_hs);
  assign w_wr_addr = (r_wstate == W_HAVE_ADDR) ? r_awaddr : awaddr;
  assign w_wr_data = (r_wstate == W_HAVE_DATA) ? r_wdata : wdata;
  assign w_wr_strb = (r_wstate == W_HAVE_DATA) ? r_wstrb : wstrb;

  // Truncating the word offset to IDX_W bits gives the modulo-depth index.
  assign w_wr_idx = IDX_W'((w_wr_addr - BASE_ADDR) >> BYTE_SHIFT);
  assign w_rd_idx = IDX_W'((araddr - BASE_ADDR) >> BYTE_SHIFT);

`ifdef AXIL_SRAM_RANGE_CHECK_EN
  // One extra bit makes an address below BASE_ADDR wrap to a huge offset,
  // so a single unsigned compare covers both ends of the window.
  assign w_wr_ok = (((ADDR_WIDTH+1)'(w_wr_addr) - (ADDR_WIDTH+1)'(BASE_ADDR))
                    < (ADDR_WIDTH+1)'(RANGE_BYTES));
  assign w_rd_ok = (((ADDR_WIDTH+1)'(araddr) - (ADDR_WIDTH+1)'(BASE_ADDR))
                    < (ADDR_WIDTH+1)'(RANGE_BYTES));
`else
  assign w_wr_ok = 1'b1;
  assign w_rd_ok = 1'b1;
`endif

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_commit) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge aclk) begin
    if (w_commit && w_wr_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_wr_strb[i]) r_mem[w_wr_idx][i*8 +: 8] <= w_wr_data[i*8 +: 8];
      end
    end
  end

  // Sampling the array with non-blocking semantics yields the pre-write
  // value when a write to the same word commits on the same edge.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
      r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign bresp = r_bresp;
  assign rdata = r_rdata;
  assign rresp = r_rresp;

endmodule

// File: tb/tb_axil_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_axil_sram_responder
//
// Directed bench for axil_sram_responder (default parameters). A word-array
// model tracks memory contents and queues the expected B and R responses;
// a negedge compare process checks every valid response against it, and the
// directed sequence pins a few literal values and handshake timings.
// ---------------------------------------------------------------------------
module tb_axil_sram_responder;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int vecCount = 0;
  int errCount = 0;

  logic [31:0] modelMem [256];
  logic [1:0]  expB [$];
  logic [31:0] expRdata [$];
  logic [1:0]  expRresp [$];

  always #5 aclk = ~aclk;

  axil_sram_responder dut (
    .aclk(aclk), .areset_n(areset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    vecCount++;
    errCount++;
    $display("[TB] FAIL %s: handshake timed out", name);
  endtask

  // Model: byte window [0, 1024) for 256 words of 4 bytes at base 0.
  function automatic int modelIndex(input logic [31:0] addr);
    return int'((addr >> 2) % 256);
  endfunction

  task automatic modelCommit(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] resp;
    resp = 2'b00;
`ifdef AXIL_SRAM_RANGE_CHECK_EN
    if (addr >= 32'd1024) resp = 2'b10;
`endif
    if (resp == 2'b00) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) modelMem[modelIndex(addr)][i*8 +: 8] = data[i*8 +: 8];
    end
    expB.push_back(resp);
  endtask

  task automatic modelRead(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    d = modelMem[modelIndex(addr)];
    r = 2'b00;
`ifdef AXIL_SRAM_RANGE_CHECK_EN
    if (addr >= 32'd1024) begin
      d = '0;
      r = 2'b10;
    end
`endif
  endtask

  // Compare process: every valid response must match the queued expectation.
  always @(negedge aclk) begin
    if (areset_n) begin
      if (bvalid) begin
        if (expB.size() == 0) reportTimeout("b_unexpected");
        else begin
          checkOutput("bresp", {62'd0, bresp}, {62'd0, expB[0]});
          if (bready) void'(expB.pop_front());
        end
      end
      if (rvalid) begin
        if (expRdata.size() == 0) reportTimeout("r_unexpected");
        else begin
          checkOutput("rdata", {32'd0, rdata}, {32'd0, expRdata[0]});
          checkOutput("rresp", {62'd0, rresp}, {62'd0, expRresp[0]});
          if (rready) begin
            void'(expRdata.pop_front());
            void'(expRresp.pop_front());
          end
        end
      end
    end
  end

  // Drivers are entered #1 after a rising edge and return #1 after the
  // edge on which their handshake happened.
  task automatic driveAw(input logic [31:0] addr);
    bit ok = 0;
    awvalid = 1'b1;
    awaddr  = addr;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (awready) begin ok = 1; break; end
      @(posedge aclk); #1;
    end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    if (!ok) reportTimeout("aw_handshake");
  endtask

  task automatic driveW(input logic [31:0] data, input logic [3:0] strb);
    bit ok = 0;
    wvalid = 1'b1;
    wdata  = data;
    wstrb  = strb;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (wready) begin ok = 1; break; end
      @(posedge aclk); #1;
    end
    @(posedge aclk); #1;
    wvalid = 1'b0;
    if (!ok) reportTimeout("w_handshake");
  endtask

  task automatic driveAr(input logic [31:0] addr);
    bit ok = 0;
    logic [31:0] d;
    logic [1:0]  r;
    arvalid = 1'b1;
    araddr  = addr;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (arready) begin ok = 1; modelRead(addr, d, r); break; end
      @(posedge aclk); #1;
    end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    if (ok) begin
      expRdata.push_back(d);
      expRresp.push_back(r);
    end else reportTimeout("ar_handshake");
  endtask

  // Entered #1 after the commit edge; bvalid must already be up.
  task automatic finishWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int bDelay, output logic [1:0] respSeen);
    int n = 0;
    modelCommit(addr, data, strb);
    bready = (bDelay == 0);
    @(negedge aclk);
    checkOutput("bvalid_after_commit", {63'd0, bvalid}, 64'd1);
    while (!(bvalid && bready) && n < 60) begin
      @(posedge aclk); #1;
      n++;
      bready = (n >= bDelay);
      @(negedge aclk);
      if (!bready) checkOutput("bvalid_hold", {63'd0, bvalid}, 64'd1);
    end
    respSeen = bresp;
    if (!(bvalid && bready)) reportTimeout("b_handshake");
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic finishRead(input int rDelay, output logic [31:0] dataSeen, output logic [1:0] respSeen);
    int n = 0;
    rready = (rDelay == 0);
    @(negedge aclk);
    checkOutput("rvalid_after_ar", {63'd0, rvalid}, 64'd1);
    while (!(rvalid && rready) && n < 60) begin
      @(posedge aclk); #1;
      n++;
      rready = (n >= rDelay);
      @(negedge aclk);
      if (!rready) checkOutput("rvalid_hold", {63'd0, rvalid}, 64'd1);
    end
    dataSeen = rdata;
    respSeen = rresp;
    if (!(rvalid && rready)) reportTimeout("r_handshake");
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic writeTxn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int bDelay, output logic [1:0] respSeen);
    fork
      driveAw(addr);
      driveW(data, strb);
    join
    finishWrite(addr, data, strb, bDelay, respSeen);
  endtask

  task automatic readTxn(input logic [31:0] addr, input int rDelay,
                         output logic [31:0] dataSeen, output logic [1:0] respSeen);
    driveAr(addr);
    finishRead(rDelay, dataSeen, respSeen);
  endtask

  task automatic checkAllIdleOutputs(input string tag);
    checkOutput({tag, "_awready"}, {63'd0, awready}, 64'd0);
    checkOutput({tag, "_wready"},  {63'd0, wready},  64'd0);
    checkOutput({tag, "_arready"}, {63'd0, arready}, 64'd0);
    checkOutput({tag, "_bvalid"},  {63'd0, bvalid},  64'd0);
    checkOutput({tag, "_rvalid"},  {63'd0, rvalid},  64'd0);
    checkOutput({tag, "_bresp"},   {62'd0, bresp},   64'd0);
    checkOutput({tag, "_rresp"},   {62'd0, rresp},   64'd0);
    checkOutput({tag, "_rdata"},   {32'd0, rdata},   64'd0);
  endtask

  task automatic releaseReset(input string tag);
    @(negedge aclk);
    areset_n = 1'b1;
    #1;
    checkOutput({tag, "_awready_pre_edge"}, {63'd0, awready}, 64'd0);
    @(posedge aclk); #1;
    checkOutput({tag, "_awready_up"}, {63'd0, awready}, 64'd1);
    checkOutput({tag, "_wready_up"},  {63'd0, wready},  64'd1);
    checkOutput({tag, "_arready_up"}, {63'd0, arready}, 64'd1);
  endtask

  task automatic applyStimulus();
    logic [31:0] d, d2;
    logic [1:0]  r, r2;

    // Power-up reset.
    repeat (3) @(posedge aclk);
    #1;
    checkAllIdleOutputs("reset");
    releaseReset("rel1");

    // AW+W together, then read back.
    writeTxn(32'h10, 32'h100, 4'hF, 0, r);
    checkOutput("t1_bresp", {62'd0, r}, 64'd0);
    readTxn(32'h10, 0, d, r);
    checkOutput("t1_rdata", {32'd0, d}, 64'h100);
    checkOutput("t1_rresp", {62'd0, r}, 64'd0);

    // W leads AW by three cycles; B held off four cycles.
    driveW(32'hDEADBEEF, 4'hF);
    repeat (2) begin
      @(negedge aclk);
      checkOutput("t2_awready_wait", {63'd0, awready}, 64'd1);
      checkOutput("t2_wready_wait",  {63'd0, wready},  64'd0);
      @(posedge aclk); #1;
    end
    driveAw(32'h20);
    finishWrite(32'h20, 32'hDEADBEEF, 4'hF, 4, r);
    checkOutput("t2_bresp", {62'd0, r}, 64'd0);
    readTxn(32'h20, 2, d, r);
    checkOutput("t2_rdata", {32'd0, d}, 64'hDEADBEEF);

    // Partial strobes.
    writeTxn(32'h30, 32'h11223344, 4'hF, 0, r);
    writeTxn(32'h30, 32'hAABBCCDD, 4'h5, 1, r);
    readTxn(32'h30, 0, d, r);
    checkOutput("t3_rdata", {32'd0, d}, 64'h11BB33DD);
    writeTxn(32'h34, 32'h99999999, 4'h0, 0, r);
    checkOutput("t3_zero_strb_bresp", {62'd0, r}, 64'd0);

    // Read and write of the same word committed on one edge.
    writeTxn(32'h40, 32'h0, 4'hF, 0, r);
    fork
      writeTxn(32'h40, 32'h55, 4'hF, 0, r2);
      readTxn(32'h40, 0, d, r);
    join
    checkOutput("t4_read_before_write", {32'd0, d}, 64'h0);
    readTxn(32'h40, 0, d, r);
    checkOutput("t4_read_after", {32'd0, d}, 64'h55);

    // Out-of-range access at 0x400.
    writeTxn(32'h0, 32'hCAFEF00D, 4'hF, 0, r);
    writeTxn(32'h400, 32'h12345678, 4'hF, 0, r);
`ifdef AXIL_SRAM_RANGE_CHECK_EN
    checkOutput("t5_oor_bresp", {62'd0, r}, 64'd2);
    readTxn(32'h400, 0, d, r);
    checkOutput("t5_oor_rdata", {32'd0, d}, 64'd0);
    checkOutput("t5_oor_rresp", {62'd0, r}, 64'd2);
    readTxn(32'h0, 0, d, r);
    checkOutput("t5_word0_kept", {32'd0, d}, 64'hCAFEF00D);
`else
    checkOutput("t5_alias_bresp", {62'd0, r}, 64'd0);
    readTxn(32'h0, 0, d, r);
    checkOutput("t5_alias_rdata", {32'd0, d}, 64'h12345678);
    checkOutput("t5_alias_rresp", {62'd0, r}, 64'd0);
`endif

    // Reset dropped while both channels are holding responses.
    fork
      begin
        fork
          driveAw(32'h50);
          driveW(32'hA5A55A5A, 4'hF);
        join
        modelCommit(32'h50, 32'hA5A55A5A, 4'hF);
      end
      driveAr(32'h10);
    join
    @(negedge aclk);
    checkOutput("t6_bvalid_before", {63'd0, bvalid}, 64'd1);
    checkOutput("t6_rvalid_before", {63'd0, rvalid}, 64'd1);
    #2;
    areset_n = 1'b0;
    expB.delete();
    expRdata.delete();
    expRresp.delete();
    #1;
    checkAllIdleOutputs("t6_async");
    @(posedge aclk); #1;
    checkAllIdleOutputs("t6_held");
    releaseReset("rel2");
    readTxn(32'h10, 0, d, r);
    checkOutput("t6_rdata_0x10", {32'd0, d}, 64'h100);
    readTxn(32'h50, 1, d2, r2);
    checkOutput("t6_rdata_0x50", {32'd0, d2}, 64'hA5A55A5A);

    checkOutput("b_queue_drained", 64'(expB.size()), 64'd0);
    checkOutput("r_queue_drained", 64'(expRdata.size()), 64'd0);
  endtask

  initial begin
    applyStimulus();
    repeat (2) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
